// File: rtl/bcd_pkg.sv
// Shared BCD constants and state encoding for the BCD <-> binary converters.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Reverse double-dabble: subtract 3 from any digit at or above 8.
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_VAL    = 3;

    // Forward double-dabble: add 3 to any digit at or above 5.
    localparam int DABBLE_THRESH = 5;
    localparam int DABBLE_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit reverse double-dabble correction: value >= 8 gets 3 subtracted.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    assign q = (d >= BCD_DIGIT_W'(ADJ_THRESH)) ? d - BCD_DIGIT_W'(ADJ_VAL) : d;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter, one bit per clock (reverse double-dabble).
// Optional BCD2BIN_DIGIT_CHK_EN adds an err output flagging digits above 9.
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int N_DIGIT = 4,
    parameter int BIN_W   = 14
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [BCD_DIGIT_W*N_DIGIT-1:0] bcd,
    output logic                           ready,
    output logic                           done_tick,
    output logic [BIN_W-1:0]               bin
`ifdef BCD2BIN_DIGIT_CHK_EN
    ,
    output logic                           err
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * N_DIGIT;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] N_INIT  = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_shift;
    logic [BCD_W-1:0] bcd_adj;
    logic [BIN_W-1:0] bin_reg;
    logic [CNT_W-1:0] n_reg;
    logic             ready_reg;
    logic             done_reg;

    // The BCD field shifts right into the top of bin_reg; each digit is then corrected.
    assign bcd_shift = bcd_reg >> 1;

    for (genvar g = 0; g < N_DIGIT; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q(bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD2BIN_DIGIT_CHK_EN
    logic err_reg;
    logic bad_in;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < N_DIGIT; i++)
            if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9))
                bad_in = 1'b1;
    end

    assign err = err_reg;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            n_reg     <= '0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_reg   <= bcd;
                        bin_reg   <= '0;
                        n_reg     <= N_INIT;
                        ready_reg <= 1'b0;
                        state     <= OP;
`ifdef BCD2BIN_DIGIT_CHK_EN
                        err_reg   <= bad_in;
`endif
                    end
                end
                OP: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
                    n_reg   <= n_reg - CNT_ONE;
                    if (n_reg == CNT_ONE) begin
                        state    <= DONE;
                        done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_reg;
    assign done_tick = done_reg;
    assign bin       = bin_reg;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin with a decimal/timeline reference model checked every cycle.
module tb_bcd2bin;

    localparam int N_DIGIT = 4;
    localparam int BIN_W   = 14;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic [15:0]       bcd     = '0;
    logic              ready;
    logic              done_tick;
    logic [BIN_W-1:0]  bin;
`ifdef BCD2BIN_DIGIT_CHK_EN
    logic              err;
`endif

    int n_vec = 0;
    int n_err = 0;

    bcd2bin #(.N_DIGIT(N_DIGIT), .BIN_W(BIN_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bcd      (bcd),
        .ready    (ready),
        .done_tick(done_tick),
        .bin      (bin)
`ifdef BCD2BIN_DIGIT_CHK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic int dec_val(input logic [15:0] v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < N_DIGIT; i++) begin
            r += int'(v[i*4 +: 4]) * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic bit valid_bcd(input logic [15:0] v);
        for (int i = 0; i < N_DIGIT; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int x = n;
        r = '0;
        for (int i = 0; i < N_DIGIT; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a conversion accepted at edge index A owns the block through edge A+BIN_W+1;
    // done is expected on the cycle following edge A+BIN_W with the decimal value of bcd.
    int e = 0;
    int m_acc = 0;
    int m_exp = 0;
    int m_res = 0;
    bit m_busy = 1'b0;
    bit m_ok = 1'b1;
    bit m_res_ok = 1'b1;
    bit m_live = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy   <= 1'b0;
            m_res    <= 0;
            m_res_ok <= 1'b1;
            m_live   <= 1'b1;
        end else begin
            e <= e + 1;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_acc  <= e + 1;
                m_exp  <= dec_val(bcd);
                m_ok   <= valid_bcd(bcd);
            end else if (m_busy && e == m_acc + BIN_W) begin
                m_busy   <= 1'b0;
                m_res    <= m_exp;
                m_res_ok <= m_ok;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && m_live) begin
            check("mon_ready", ready, !m_busy);
            check("mon_done_tick", done_tick, m_busy && (e == m_acc + BIN_W));
            if (m_busy && e == m_acc + BIN_W) begin
                if (m_ok) check("mon_bin_done", bin, m_exp);
            end else if (!m_busy && m_res_ok) begin
                check("mon_bin_hold", bin, m_res);
            end
        end
    end

    // Called at posedge+1; returns at the negedge where done_tick is seen.
    task automatic conv(input logic [15:0] v, output int lat, output logic [BIN_W-1:0] b);
        int w = 0;
        while (ready !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (ready !== 1'b1) check("ready_wait_timeout", ready, 1);
        bcd   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done_tick !== 1'b1 && lat < 40);
        if (done_tick !== 1'b1) check("done_wait_timeout", done_tick, 1);
        b = bin;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gap;
        int seen;
        logic [BIN_W-1:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ready, 1);
        check("reset_done_tick", done_tick, 0);
        check("reset_bin", bin, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        conv(16'h9999, lat, b);
        check("lat_9999", lat, 15);
        check("bin_9999", b, 14'h270F);

        // Zero with start held high; bcd changes mid-conversion, then back-to-back 1234.
        @(posedge clk); #1;
        bcd   = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 5) bcd = 16'h1234;
        end while (done_tick !== 1'b1 && lat < 40);
        check("lat_0000", lat, 15);
        check("bin_0000", bin, 0);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 2) start = 1'b0;
        end while (done_tick !== 1'b1 && gap < 40);
        start = 1'b0;
        check("b2b_gap", gap, BIN_W + 2);
        check("bin_1234", bin, 14'h04D2);

        // Asynchronous reset on the 7th OP cycle of 0500.
        @(posedge clk); #1;
        bcd   = 16'h0500;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_bin", bin, 0);
        check("midrst_done_tick", done_tick, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_tick === 1'b1) seen++;
        end
        check("midrst_no_done", seen, 0);
        @(posedge clk); #1;
        conv(16'h0042, lat, b);
        check("lat_0042", lat, 15);
        check("bin_0042", b, 14'd42);

`ifdef BCD2BIN_DIGIT_CHK_EN
        @(posedge clk); #1;
        conv(16'h12A4, lat, b);
        check("err_12A4", err, 1);
        check("lat_12A4", lat, 15);
        @(posedge clk); #1;
        conv(16'h0007, lat, b);
        check("err_0007", err, 0);
        check("bin_0007", b, 14'd7);
`endif

        for (int i = 0; i < 10000; i += 101) begin
            @(posedge clk); #1;
            conv(to_bcd(i), lat, b);
            check("sweep_bin", b, i);
            check("sweep_lat", lat, 15);
        end
        @(posedge clk); #1;
        conv(16'h1000, lat, b);
        check("bin_1000", b, 14'd1000);
        @(posedge clk); #1;
        conv(16'h0809, lat, b);
        check("bin_0809", b, 14'd809);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
